// File: rtl/gbp_update_queue.sv
// rtl/gbp_update_queue.sv - circular FIFO buffering resolved branch updates for the predictor
module gbp_update_queue #(
  parameter int DEPTH   = 4,
  parameter int VLEN    = 64,
  parameter int INDEX_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  input  logic                     upd_valid_i,
  input  logic [VLEN-1:0]          upd_pc_i,
  input  logic                     upd_taken_i,
  input  logic [INDEX_W-1:0]       upd_index_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [VLEN-1:0]          out_pc_o,
  output logic                     out_taken_o,
  output logic [INDEX_W-1:0]       out_index_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [VLEN-1:0]    r_pc_mem    [DEPTH];
  logic               r_taken_mem [DEPTH];
  logic [INDEX_W-1:0] r_index_mem [DEPTH];

  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_drop_cnt;

  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake decode; a pop on a full queue frees the slot the incoming update lands in
  always_comb begin
    w_full     = (r_count == CNT_W'(DEPTH));
    w_empty    = (r_count == '0);
    w_push_req = upd_valid_i && !debug_mode_i && !flush_i;
    w_pop      = !w_empty && out_ready_i;
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Pointer, occupancy, storage and drop-counter state; flush clears occupancy but keeps the drop count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_taken_mem[i] <= 1'b0;
        r_index_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= upd_pc_i;
        r_taken_mem[r_wr_ptr] <= upd_taken_i;
        r_index_mem[r_wr_ptr] <= upd_index_i;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Head entry is read straight out of storage; no bypass from the write port
  always_comb begin
    out_valid_o = !w_empty;
    out_pc_o    = r_pc_mem[r_rd_ptr];
    out_taken_o = r_taken_mem[r_rd_ptr];
    out_index_o = r_index_mem[r_rd_ptr];
    count_o     = r_count;
    drop_cnt_o  = r_drop_cnt;
  end

endmodule

// File: doc/gbp_update_queue.md
GBP_UPDATE_QUEUE -- requirements
Module: gbp_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL have parameter VLEN, default 64, meaning the width of the branch PC.
REQ-003 SHALL have parameter INDEX_W, default 8, meaning the width of the predictor table index carried as metadata.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 Port flush_i, input, 1 bit: branch-prediction flush; discards all queued updates.
REQ-007 Port debug_mode_i, input, 1 bit: when high, incoming updates are discarded.
REQ-008 Port upd_valid_i, input, 1 bit: a resolved branch update is presented this cycle (fire-and-forget, no backpressure).
REQ-009 Port upd_pc_i, input, VLEN bits: PC of the resolved branch.
REQ-010 Port upd_taken_i, input, 1 bit: resolved direction.
REQ-011 Port upd_index_i, input, INDEX_W bits: predictor index captured at prediction time.
REQ-012 Port out_valid_o, output, 1 bit: head entry is available to the predictor.
REQ-013 Port out_ready_i, input, 1 bit: the predictor consumes the head entry this cycle.
REQ-014 Port out_pc_o, output, VLEN bits: PC of the head entry.
REQ-015 Port out_taken_o, output, 1 bit: direction of the head entry.
REQ-016 Port out_index_o, output, INDEX_W bits: index of the head entry.
REQ-017 Port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-018 Port drop_cnt_o, output, 16 bits: saturating count of updates lost to overflow.

Function
REQ-019 The queue SHALL be a circular FIFO with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-020 Push condition: upd_valid_i && !debug_mode_i && !flush_i, and the queue is not full or a pop occurs in the same cycle.
REQ-021 Pop condition: out_valid_o && out_ready_i.
REQ-022 out_valid_o SHALL equal (count_o != 0); the out_* data ports SHALL present the head entry directly from storage.
REQ-023 Latency: an entry pushed in cycle N SHALL be visible on out_* in cycle N+1; there is no same-cycle bypass.
REQ-024 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers, including when the queue is full.
REQ-025 Overflow: upd_valid_i && !debug_mode_i && !flush_i while full and no pop SHALL drop the new update, leave the queue contents unchanged, and increment drop_cnt_o, which saturates at 16'hFFFF.
REQ-026 Updates presented with debug_mode_i high SHALL be discarded silently and SHALL NOT increment drop_cnt_o.
REQ-027 flush_i SHALL zero count_o and both pointers on the next edge, overriding any push or pop in the same cycle; drop_cnt_o is unaffected.
REQ-028 out_* data while out_valid_o is low is don't-care for verification but SHALL NOT be X in simulation after reset.
REQ-029 count_o SHALL never exceed DEPTH.

Reset
REQ-030 rst_i high at a rising edge SHALL set the pointers, count_o and drop_cnt_o to 0, zero all storage, and force out_valid_o to 0 in the following cycle, regardless of flush_i, upd_valid_i or out_ready_i.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries; the first push after rst_i deasserts SHALL behave as on an empty queue.

Verification
REQ-032 Single update: reset, push pc=0x1000, taken=1, index=0x2A with out_ready_i=0 -> next cycle out_valid_o=1, out_pc_o=0x1000, out_taken_o=1, out_index_o=0x2A, count_o=1.
REQ-033 Fill and overflow (DEPTH=4): 5 pushes with out_ready_i=0 -> count_o=4, drop_cnt_o=1, head is the first push; 4 pops return the first four updates in order.
REQ-034 Full with simultaneous push and pop: queue full, push 0x2000 while out_ready_i=1 -> count_o stays 4, drop_cnt_o unchanged, 0x2000 emerges as the 4th subsequent pop.
REQ-035 Debug gating: debug_mode_i=1 with 3 pushes -> count_o=0, drop_cnt_o=0, out_valid_o=0.
REQ-036 Flush priority: 2 entries queued, then flush_i=1 with a push and a pop in the same cycle -> next cycle count_o=0, out_valid_o=0; drop_cnt_o is retained.
REQ-037 Wrap-around and saturation: 1000 random push/pop cycles checked against a reference model across pointer wrap; force 70000 overflows -> drop_cnt_o=16'hFFFF.
